// File: rtl/hash_core_scheduler.sv
`default_nettype none
// hash_core_scheduler: launches NUM_CORES nonce-search cores on disjoint ranges and
// shares one memory port among them with a locking round-robin arbiter. Rev 1.0
module hash_core_scheduler #(
  parameter int NUM_CORES       = 4,
  parameter int NONCES_PER_CORE = 16,
  parameter int ADDR_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           input_addr,
  input  logic [ADDR_W-1:0]           hash_addr,
  output logic                        done,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [NUM_CORES*ADDR_W-1:0] core_input_addr,
  output logic [NUM_CORES*ADDR_W-1:0] core_hash_addr,
  output logic [NUM_CORES*32-1:0]     core_nonce_base,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES-1:0]        core_mem_req,
  input  logic [NUM_CORES-1:0]        core_mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_mem_addr,
  input  logic [NUM_CORES*32-1:0]     core_mem_wdata,
  output logic [NUM_CORES-1:0]        core_mem_gnt,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata
);

  localparam int RR_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_RUN} state_t;

  state_t                      state_q;
  logic                        done_q;
  logic [NUM_CORES-1:0]        core_start_q;
  logic [NUM_CORES-1:0]        done_seen_q;
  logic [NUM_CORES*ADDR_W-1:0] input_addr_q;
  logic [NUM_CORES*ADDR_W-1:0] hash_addr_q, hash_addr_d;
  logic [NUM_CORES*32-1:0]     nonce_base_q, nonce_base_d;
  logic [NUM_CORES-1:0]        done_seen_d;

  logic [NUM_CORES-1:0]        gnt_q, gnt_d;
  logic [RR_W-1:0]             rr_q, rr_d;

  always_comb begin
    hash_addr_d  = '0;
    nonce_base_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hash_addr_d[i*ADDR_W +: ADDR_W] = hash_addr + ADDR_W'(i * NONCES_PER_CORE);
      nonce_base_d[i*32 +: 32]        = 32'(i * NONCES_PER_CORE);
    end
  end

  assign done_seen_d = done_seen_q | core_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b1;
      core_start_q <= '0;
      done_seen_q  <= '0;
      input_addr_q <= '0;
      hash_addr_q  <= '0;
      nonce_base_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            input_addr_q <= {NUM_CORES{input_addr}};
            hash_addr_q  <= hash_addr_d;
            nonce_base_q <= nonce_base_d;
            core_start_q <= '1;
            done_q       <= 1'b0;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          core_start_q <= '0;
          done_seen_q  <= '0;
          state_q      <= S_SETTLE;
        end
        // Cores still report done here because they drop it one cycle after start.
        S_SETTLE: state_q <= S_RUN;
        S_RUN: begin
          done_seen_q <= done_seen_d;
          if (&done_seen_d) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done            = done_q;
  assign core_start      = core_start_q;
  assign core_input_addr = input_addr_q;
  assign core_hash_addr  = hash_addr_q;
  assign core_nonce_base = nonce_base_q;

  // The owner holds while requesting; otherwise search from rr+1 so the last owner ranks lowest.
  always_comb begin
    logic            found;
    int              idx;
    logic [RR_W-1:0] sel;
    gnt_d = gnt_q;
    rr_d  = rr_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    if ((gnt_q & core_mem_req) == '0) begin
      gnt_d = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        sel = RR_W'(idx);
        if (!found && core_mem_req[sel]) begin
          found      = 1'b1;
          gnt_d[sel] = 1'b1;
          rr_d       = sel;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      rr_q  <= RR_W'(NUM_CORES - 1);
    end else begin
      gnt_q <= gnt_d;
      rr_q  <= rr_d;
    end
  end

  assign core_mem_gnt = gnt_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_q[i]) begin
        mem_we    = core_mem_we[i] & core_mem_req[i];
        mem_addr  = core_mem_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = core_mem_wdata[i*32 +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_core_scheduler.sv
`default_nettype none
// tb_hash_core_scheduler: directed self-checking bench for hash_core_scheduler. Rev 1.0
module tb_hash_core_scheduler;

  localparam int NC  = 4;
  localparam int NPC = 16;
  localparam int AW  = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    input_addr;
  logic [AW-1:0]    hash_addr;
  logic             done;
  logic [NC-1:0]    core_start;
  logic [NC*AW-1:0] core_input_addr;
  logic [NC*AW-1:0] core_hash_addr;
  logic [NC*32-1:0] core_nonce_base;
  logic [NC-1:0]    core_done;
  logic [NC-1:0]    core_mem_req;
  logic [NC-1:0]    core_mem_we;
  logic [NC*AW-1:0] core_mem_addr;
  logic [NC*32-1:0] core_mem_wdata;
  logic [NC-1:0]    core_mem_gnt;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [NC-1:0] we_pat;

  hash_core_scheduler #(
    .NUM_CORES(NC), .NONCES_PER_CORE(NPC), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .input_addr(input_addr), .hash_addr(hash_addr),
    .done(done), .core_start(core_start),
    .core_input_addr(core_input_addr), .core_hash_addr(core_hash_addr),
    .core_nonce_base(core_nonce_base), .core_done(core_done),
    .core_mem_req(core_mem_req), .core_mem_we(core_mem_we),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
    .core_mem_gnt(core_mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    input_addr   = '0;
    hash_addr    = '0;
    core_done    = 4'b1111;
    core_mem_req = '0;
    we_pat       = 4'b0101;
    core_mem_we  = we_pat;
    for (int i = 0; i < NC; i++) begin
      core_mem_addr[i*AW +: AW]  = 16'h1000 + 16'(i * 17);
      core_mem_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end

    // 1: reset and idle
    repeat (2) @(negedge clk);
    chk("rst_done_during", {63'd0, done}, 64'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_done", {63'd0, done}, 64'd1);
    chk("idle_core_start", {60'd0, core_start}, 64'd0);
    chk("idle_gnt", {60'd0, core_mem_gnt}, 64'd0);
    chk("idle_mem_we", {63'd0, mem_we}, 64'd0);
    chk("idle_mem_addr", {48'd0, mem_addr}, 64'd0);

    // 2: launch
    start      = 1'b1;
    input_addr = 16'h0000;
    hash_addr  = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    chk("launch_core_start", {60'd0, core_start}, 64'hF);
    chk("launch_done", {63'd0, done}, 64'd0);
    chk("launch_hash_addr", core_hash_addr, 64'h0130_0120_0110_0100);
    chk("launch_input_addr", core_input_addr, 64'h0);
    chk("launch_nonce_lo", core_nonce_base[63:0], 64'h0000_0010_0000_0000);
    chk("launch_nonce_hi", core_nonce_base[127:64], 64'h0000_0030_0000_0020);
    @(negedge clk);
    chk("settle_core_start", {60'd0, core_start}, 64'd0);
    chk("settle_done", {63'd0, done}, 64'd0);

    // 5: completion order 2,0,3,1; start during RUN is ignored
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      if (n <= 40) chk("run_done_low", {63'd0, done}, 64'd0);
      if (n == 26 || n == 27) chk("run_no_restart", {60'd0, core_start}, 64'd0);
      if (n == 41) begin
        chk("run_done_high", {63'd0, done}, 64'd1);
        chk("run_end_core_start", {60'd0, core_start}, 64'd0);
      end
      case (n)
        1:  core_done = 4'b0000;
        10: core_done[2] = 1'b1;
        20: core_done[0] = 1'b1;
        25: start = 1'b1;
        26: start = 1'b0;
        30: core_done[3] = 1'b1;
        40: core_done[1] = 1'b1;
        default: ;
      endcase
    end
    @(negedge clk);
    chk("idle_after_run_done", {63'd0, done}, 64'd1);
    chk("idle_after_run_start", {60'd0, core_start}, 64'd0);

    // 3: four requesters, three-cycle bursts, back-to-back handoff
    core_mem_req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      int own;
      own = k / 3;
      @(negedge clk);
      chk("rr_gnt", {60'd0, core_mem_gnt}, 64'd1 << own);
      chk("rr_mem_addr", {48'd0, mem_addr}, 64'h1000 + 64'(own * 17));
      chk("rr_mem_we", {63'd0, mem_we}, {63'd0, we_pat[own]});
      chk("rr_mem_wdata", {32'd0, mem_wdata}, 64'hA000_0000 + 64'(own));
      if (k % 3 == 2) begin
        core_mem_req[own] = 1'b0;
        #1;
        chk("rr_release_we", {63'd0, mem_we}, 64'd0);
      end
    end
    @(negedge clk);
    chk("rr_all_released", {60'd0, core_mem_gnt}, 64'd0);
    chk("rr_released_addr", {48'd0, mem_addr}, 64'd0);

    // 4: core1 releases with core0 and core3 waiting, rr=1 -> core3 first
    core_mem_req = 4'b0010;
    @(negedge clk);
    chk("p4_gnt_core1", {60'd0, core_mem_gnt}, 64'b0010);
    core_mem_req = 4'b1011;
    @(negedge clk);
    chk("p4_core1_holds", {60'd0, core_mem_gnt}, 64'b0010);
    core_mem_req = 4'b1001;
    @(negedge clk);
    chk("p4_gnt_core3", {60'd0, core_mem_gnt}, 64'b1000);
    core_mem_req = 4'b0001;
    @(negedge clk);
    chk("p4_gnt_core0", {60'd0, core_mem_gnt}, 64'b0001);
    core_mem_req = 4'b0000;
    @(negedge clk);
    chk("p4_gnt_none", {60'd0, core_mem_gnt}, 64'd0);
    chk("p4_wdata_none", {32'd0, mem_wdata}, 64'd0);

    // second run with wrapping output window, then reset mid-run
    start      = 1'b1;
    input_addr = 16'h1234;
    hash_addr  = 16'hFFF0;
    @(negedge clk);
    start = 1'b0;
    chk("wrap_core_start", {60'd0, core_start}, 64'hF);
    chk("wrap_hash_addr", core_hash_addr, 64'h0020_0010_0000_FFF0);
    chk("wrap_input_addr", core_input_addr, 64'h1234_1234_1234_1234);
    core_mem_req = 4'b0100;
    @(negedge clk);
    chk("c2_gnt", {60'd0, core_mem_gnt}, 64'b0100);
    chk("c2_mem_we", {63'd0, mem_we}, 64'd1);
    chk("c2_mem_addr", {48'd0, mem_addr}, 64'h1022);
    chk("c2_done_low", {63'd0, done}, 64'd0);

    // 6: asynchronous reset while core2 writes
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", {60'd0, core_mem_gnt}, 64'd0);
    chk("arst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    rst_n        = 1'b1;
    core_mem_req = 4'b1111;
    chk("post_rst_done", {63'd0, done}, 64'd1);
    chk("post_rst_core_start", {60'd0, core_start}, 64'd0);
    chk("post_rst_hash_addr", core_hash_addr, 64'd0);
    chk("post_rst_input_addr", core_input_addr, 64'd0);
    chk("post_rst_nonce_hi", core_nonce_base[127:64], 64'd0);
    @(negedge clk);
    chk("post_rst_rr_ptr", {60'd0, core_mem_gnt}, 64'b0001);
    core_mem_req = 4'b0000;
    @(negedge clk);
    chk("post_rst_release", {60'd0, core_mem_gnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hash_core_scheduler.md
Name: hash_core_scheduler

Overview:
- Top-level sequencer for a multi-core bitcoin nonce search.
- Launches NUM_CORES hash cores in parallel and gives each a disjoint nonce range and output window.
- Arbitrates the single shared memory port among the cores with a locking round-robin scheme.
- Reports done when every core has finished its batch.

Parameters:
- NUM_CORES, 4, number of hash cores driven; must be 2..8.
- NONCES_PER_CORE, 16, nonces per core per run; also the output-word stride between cores.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- input_addr  in  ADDR_W  base of the 19-word block header
- hash_addr  in  ADDR_W  base of the output hash words
- done  out  1  high exactly when the FSM is in IDLE
- core_start  out  NUM_CORES  per-core one-cycle start pulse
- core_input_addr  out  NUM_CORES*ADDR_W  per-core header base
- core_hash_addr  out  NUM_CORES*ADDR_W  per-core output base
- core_nonce_base  out  NUM_CORES*32  per-core first nonce
- core_done  in  NUM_CORES  per-core level, high while that core is idle
- core_mem_req  in  NUM_CORES  per-core memory request, held for a whole burst
- core_mem_we  in  NUM_CORES  per-core write enable
- core_mem_addr  in  NUM_CORES*ADDR_W  per-core address
- core_mem_wdata  in  NUM_CORES*32  per-core write data
- core_mem_gnt  out  NUM_CORES  one-hot grant, or all zero
- mem_we  out  1  shared-port write enable
- mem_addr  out  ADDR_W  shared-port address
- mem_wdata  out  32  shared-port write data

Behaviour:
- Reset state (asynchronous): FSM=IDLE, done=1, core_start=0, core_mem_gnt=0, rr pointer=NUM_CORES-1, done_seen=0, latched addresses=0.
- Core i outputs (registered, held until the next accepted start):
  - core_input_addr[i] = input_addr
  - core_hash_addr[i] = hash_addr + i*NONCES_PER_CORE, modulo 2^ADDR_W
  - core_nonce_base[i] = i*NONCES_PER_CORE
- FSM states:
  - IDLE: on start=1, latch the addresses and go to LAUNCH. With start=0, stay in IDLE.
  - LAUNCH, 1 cycle: core_start = all ones; clear done_seen; go to SETTLE.
  - SETTLE, 1 cycle: core_done is ignored, since cores take one cycle to drop done; go to RUN.
  - RUN: done_seen[i] is set sticky when core_done[i]=1. When done_seen is all ones, go to IDLE. done rises the cycle after the last done_seen bit sets.
- start outside IDLE is ignored; it is not queued.
- Arbiter (registered grant, active in all FSM states):
  - Owner = the core with core_mem_gnt=1.
  - Owner keeps the grant while its core_mem_req stays 1. There is no timeout.
  - If there is no owner, or the owner drops req in cycle t, the grant for cycle t+1 is chosen from req sampled at t. Priority starts at rr pointer+1 and wraps around; the owner that just released has lowest priority.
  - If no requester exists, gnt=0.
  - On each new grant, rr pointer is set to the granted index.
  - Handoff takes 1 cycle. No dead cycle is inserted when another requester is waiting.
- Shared port (combinational mux of the owner):
  - With an owner: mem_we = core_mem_we[owner] & core_mem_req[owner]; mem_addr and mem_wdata follow the owner.
  - With no owner: mem_we=0, mem_addr=0, mem_wdata=0.
- A core raising req in the same cycle the owner releases competes normally in round-robin.
- rst_n low mid-run: immediate return to the reset state. The grant is dropped that cycle and mem_we=0 combinationally.

Test Plan:
1. Reset, then idle 5 cycles → done=1, core_start=0, core_mem_gnt=0, mem_we=0.
2. start with input_addr=0x0000, hash_addr=0x0100, NUM_CORES=4:
   - core_start=4'b1111 for exactly 1 cycle.
   - core_hash_addr = 0x0100, 0x0110, 0x0120, 0x0130.
   - core_nonce_base = 0, 16, 32, 48.
   - done=0 from the cycle after start.
3. core_mem_req=4'b1111 held, with each core dropping req after 3 granted cycles → grant order 0,1,2,3; each grant lasts 3 cycles; handoffs are back-to-back; mem_addr tracks the owner's address.
4. core1 releases while core0 and core3 are requesting and rr pointer=1 → core3 is granted next, not core0.
5. core_done rises in order 2,0,3,1 at cycles 10,20,30,40 after SETTLE → FSM stays in RUN until the cycle-40 sample; done=1 on the following cycle. A start pulse at cycle 25 produces no second core_start.
6. rst_n pulsed low while core2 is granted and writing → same cycle: mem_we=0, gnt=0; after release: done=1 and all reset values restored.
